pipeline_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Combines the load-use stall

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/pipe_perf_cnt.sv | 25 ++
 rtl/pipeline_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encodings, default latencies
// and counter width.
package pipeline_pkg;

  localparam logic [0:0] StRun    = 1'b0;
  localparam logic [0:0] StMdBusy = 1'b1;

  localparam int unsigned MulCyclesDef = 4;
  localparam int unsigned DivCyclesDef = 16;
  localparam int unsigned CntWDef      = 32;

  // Down-counter width for a given maximum MUL/DIV latency; never narrower than one bit.
  function automatic int unsigned md_cnt_width(input int unsigned max_lat);
    return (max_lat > 1) ? $clog2(max_lat) : 1;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Enable-driven wrapping performance counter with synchronous active-high reset.
module pipe_perf_cnt
  import pipeline_pkg::*;
#(
  parameter int unsigned Width = CntWDef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates branch redirects, MUL/DIV freezes
// and load-use stalls into per-stage write enables and flushes, with perf counters.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MulCyclesDef,
  parameter int unsigned DIV_CYCLES = DivCyclesDef,
  parameter int unsigned CNT_W      = CntWDef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_stall,
  input  logic             branch_ex,
  input  logic             md_start,
  input  logic             md_is_div,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_we,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned MaxLat = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned MdCntW = md_cnt_width(MaxLat);

  logic [0:0]        state_q, state_d;
  logic [MdCntW-1:0] md_cnt_q, md_cnt_d;
  logic [31:0]       lat;
  logic              flush_inc;
  logic              stall_inc;

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_we     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_we    = 1'b1;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    flush_inc    = 1'b0;
    lat          = md_is_div ? 32'(DIV_CYCLES) : 32'(MUL_CYCLES);

    if (rst) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_we     = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_we    = 1'b0;
    end else if (state_q == StMdBusy && md_cnt_q != '0) begin
      // EX holds the MUL/DIV: freeze the front end and bubble MEM.
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_flush = 1'b1;
      md_busy      = 1'b1;
      md_cnt_d     = md_cnt_q - 1'b1;
    end else begin
      // RUN, or the release cycle of MD_BUSY (md_start is not sampled on release).
      if (state_q == StMdBusy) begin
        md_done = 1'b1;
        state_d = StRun;
      end
      if (branch_ex) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_inc   = 1'b1;
      end else if (state_q == StRun && md_start && lat >= 32'd2) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_flush = 1'b1;
        md_busy      = 1'b1;
        md_cnt_d     = MdCntW'(lat - 32'd2);
        state_d      = StMdBusy;
      end else if (hz_stall) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign stall_inc = ~rst & ~pc_we;

  pipe_perf_cnt #(
    .Width(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (stall_inc),
    .count(stall_cycles)
  );

  pipe_perf_cnt #(
    .Width(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (flush_inc),
    .count(flush_events)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed per-cycle vectors push expected outputs, a
// negedge monitor pops and compares.
module tb_pipeline_ctrl;

  // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush, mem_wb_we, busy, done}
  localparam logic [8:0] ORun    = 9'b1_1_0_1_0_0_1_0_0;
  localparam logic [8:0] ORst    = 9'b0_0_1_0_1_1_0_0_0;
  localparam logic [8:0] OFrz    = 9'b0_0_0_0_0_1_1_1_0;
  localparam logic [8:0] OHz     = 9'b0_0_0_1_1_0_1_0_0;
  localparam logic [8:0] OBr     = 9'b1_1_1_1_1_0_1_0_0;
  localparam logic [8:0] ODone   = 9'b1_1_0_1_0_0_1_0_1;
  localparam logic [8:0] ODoneHz = 9'b0_0_0_1_1_0_1_0_1;

  typedef struct packed {
    logic [8:0]  o;
    logic [31:0] sc;
    logic [31:0] fe;
    logic [31:0] id;
  } exp_t;

  logic        clk;
  logic        rst, hz_stall, branch_ex, md_start, md_is_div;
  logic        pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush, mem_wb_we;
  logic        md_busy, md_done;
  logic [31:0] stall_cycles, flush_events;
  logic [8:0]  obs;

  exp_t        q[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  int          step_id = 0;
  logic [31:0] exp_sc = 0;
  logic [31:0] exp_fe = 0;

  pipeline_ctrl #(
    .MUL_CYCLES(4),
    .DIV_CYCLES(16),
    .CNT_W     (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hz_stall    (hz_stall),
    .branch_ex   (branch_ex),
    .md_start    (md_start),
    .md_is_div   (md_is_div),
    .pc_we       (pc_we),
    .if_id_we    (if_id_we),
    .if_id_flush (if_id_flush),
    .id_ex_we    (id_ex_we),
    .id_ex_flush (id_ex_flush),
    .ex_mem_flush(ex_mem_flush),
    .mem_wb_we   (mem_wb_we),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  assign obs = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush, mem_wb_we,
                md_busy, md_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (obs !== e.o) begin
        bad++;
        $display("FAIL step%0d outputs got=%b want=%b", e.id, obs, e.o);
      end
      total++;
      if (stall_cycles !== e.sc) begin
        bad++;
        $display("FAIL step%0d stall_cycles got=%0d want=%0d", e.id, stall_cycles, e.sc);
      end
      total++;
      if (flush_events !== e.fe) begin
        bad++;
        $display("FAIL step%0d flush_events got=%0d want=%0d", e.id, flush_events, e.fe);
      end
    end
  end

  // Drive one cycle of inputs and queue the hand-written expected outputs for it.
  task automatic step(input logic r, input logic h, input logic b, input logic m,
                      input logic d, input logic [8:0] o);
    @(posedge clk);
    #1;
    rst       = r;
    hz_stall  = h;
    branch_ex = b;
    md_start  = m;
    md_is_div = d;
    q.push_back('{o: o, sc: exp_sc, fe: exp_fe, id: 32'(step_id)});
    step_id++;
    if (r) begin
      exp_sc = 0;
      exp_fe = 0;
    end else begin
      if (!o[8]) exp_sc = exp_sc + 1;
      if (o[6]) exp_fe = exp_fe + 1;
    end
  endtask

  initial begin
    rst = 1'b1; hz_stall = 1'b0; branch_ex = 1'b0; md_start = 1'b0; md_is_div = 1'b0;
    @(posedge clk);

    // Reset held with md_start asserted
    step(1, 0, 0, 1, 0, ORst);
    step(1, 0, 0, 1, 0, ORst);
    step(0, 0, 0, 0, 0, ORun);

    // Load-use stall for one cycle
    step(0, 1, 0, 0, 0, OHz);
    step(0, 0, 0, 0, 0, ORun);

    // MUL: freeze cycles 0-2, done on 3; md_start held on release is not sampled
    step(0, 0, 0, 1, 0, OFrz);
    step(0, 0, 0, 0, 0, OFrz);
    step(0, 0, 0, 0, 0, OFrz);
    step(0, 0, 0, 1, 0, ODone);
    step(0, 0, 0, 0, 0, ORun);

    // Branch beats hz_stall and md_start
    step(0, 1, 1, 0, 0, OBr);
    step(0, 0, 0, 0, 0, ORun);
    step(0, 0, 1, 1, 1, OBr);
    step(0, 0, 0, 0, 0, ORun);

    // DIV aborted by reset on cycle 5, then a full DIV
    step(0, 0, 0, 1, 1, OFrz);
    for (int i = 1; i < 5; i++) step(0, 0, 0, 0, 0, OFrz);
    step(1, 0, 0, 0, 0, ORst);
    step(0, 0, 0, 0, 0, ORun);
    step(0, 0, 0, 1, 1, OFrz);
    for (int i = 1; i < 15; i++) step(0, 0, 0, 0, 0, OFrz);
    step(0, 0, 0, 0, 0, ODone);
    step(0, 0, 0, 0, 0, ORun);

    // MUL over hz_stall; hz_stall during freeze ignored; honoured on release
    step(0, 1, 0, 1, 0, OFrz);
    step(0, 1, 0, 0, 0, OFrz);
    step(0, 0, 0, 0, 0, OFrz);
    step(0, 1, 0, 0, 0, ODoneHz);
    step(0, 0, 0, 0, 0, ORun);
    step(0, 0, 0, 0, 0, ORun);

    @(posedge clk);
    @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
